// File: rtl/mul_writeback_sequencer_if.sv
// Execute-stage / register-file side bundle of the multiply writeback sequencer.
// The master drives the MUL request from execute; the slave (the sequencer)
// returns stall, status and the register-file write port.
interface mul_writeback_sequencer_if #(
  parameter int RA_W = 5
);
  logic            issue_mul;
  logic [RA_W-1:0] DA;
  logic [63:0]     F_mul;
  logic            flush;
  logic            stall;
  logic            rf_we;
  logic [RA_W-1:0] rf_wa;
  logic [31:0]     rf_wd;
  logic            busy;
  logic            mul_done;

  modport master (
    output issue_mul, DA, F_mul, flush,
    input  stall, rf_we, rf_wa, rf_wd, busy, mul_done
  );

  modport slave (
    input  issue_mul, DA, F_mul, flush,
    output stall, rf_we, rf_wa, rf_wd, busy, mul_done
  );
endinterface

// File: rtl/mul_writeback_sequencer.sv
// Multiply writeback sequencer: stalls the pipeline while a MUL is in flight,
// waits MUL_LAT cycles for the 64-bit product, then writes the low word to DA
// and the high word to DA+1 over two cycles through the single RF write port.
module mul_writeback_sequencer #(
  parameter int MUL_LAT = 2,
  parameter int RA_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  mul_writeback_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WR_LO = 2'd2,
    ST_WR_HI = 2'd3
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

  state_e          r_state;
  logic [3:0]      r_cnt;
  logic [RA_W-1:0] r_dst;
  logic [63:0]     r_prod;

  state_e          w_state_nxt;
  logic [3:0]      w_cnt_nxt;
  logic [RA_W-1:0] w_dst_nxt;
  logic [63:0]     w_prod_nxt;
  logic [RA_W-1:0] w_dst_inc;
  logic            w_stall;
  logic            w_rf_we;
  logic [RA_W-1:0] w_rf_wa;
  logic [31:0]     w_rf_wd;
  logic            w_mul_done;

  // High word goes to the next register; wraps modulo 2^RA_W so R31 -> R0.
  assign w_dst_inc = r_dst + RA_W'(1);

  // State register and datapath holding registers.
  // NOTE: reset is synchronous (sampled only on the rising edge), and every
  // state bit uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dst   <= '0;
      r_prod  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dst   <= w_dst_nxt;
      r_prod  <= w_prod_nxt;
    end
  end

  // Next-state and output decode; issue_mul is only looked at in IDLE so the
  // stalled MUL holding it high cannot retrigger the sequence.
  // NOTE: every signal gets a default first so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dst_nxt   = r_dst;
    w_prod_nxt  = r_prod;
    w_stall     = 1'b0;
    w_rf_we     = 1'b0;
    w_rf_wa     = '0;
    w_rf_wd     = '0;
    w_mul_done  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.issue_mul && !bus.flush) begin
          w_stall     = 1'b1;
          w_dst_nxt   = bus.DA;
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (bus.flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_prod_nxt  = bus.F_mul;
          w_state_nxt = ST_WR_LO;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_WR_LO: begin
        w_stall     = 1'b1;
        w_rf_we     = 1'b1;
        w_rf_wa     = r_dst;
        w_rf_wd     = r_prod[31:0];
        w_state_nxt = ST_WR_HI;
      end
      ST_WR_HI: begin
        // R0 is hard-wired; a wrapped high-word write is suppressed.
        w_rf_we     = (w_dst_inc != '0);
        w_rf_wa     = w_dst_inc;
        w_rf_wd     = r_prod[63:32];
        w_mul_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stall is forced low while reset is asserted; the write port depends only on state.
  assign bus.stall    = w_stall & ~rst;
  assign bus.rf_we    = w_rf_we;
  assign bus.rf_wa    = w_rf_wa;
  assign bus.rf_wd    = w_rf_wd;
  assign bus.mul_done = w_mul_done;
  assign bus.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mul_writeback_sequencer.sv
// Testbench: three sequencers (MUL_LAT = 2, 1, 15) share clock and reset.
// Expected writes are queued per instance when a MUL is issued and popped by
// a negedge monitor whenever the instance shows rf_we or mul_done.
module tb_mul_writeback_sequencer;

  localparam int NDUT = 3;
  localparam int LATS [NDUT] = '{2, 1, 15};

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        done;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  logic started = 1'b0;

  logic        r_issue [NDUT];
  logic [4:0]  r_da    [NDUT];
  logic [63:0] r_fmul  [NDUT];
  logic        r_flush [NDUT];

  logic        w_stall [NDUT];
  logic        w_we    [NDUT];
  logic [4:0]  w_wa    [NDUT];
  logic [31:0] w_wd    [NDUT];
  logic        w_busy  [NDUT];
  logic        w_done  [NDUT];

  exp_t sb_q [NDUT][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mul_writeback_sequencer_if #(.RA_W(5)) u_if ();

    mul_writeback_sequencer #(.MUL_LAT(LATS[g]), .RA_W(5)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );

    assign u_if.issue_mul = r_issue[g];
    assign u_if.DA        = r_da[g];
    assign u_if.F_mul     = r_fmul[g];
    assign u_if.flush     = r_flush[g];
    assign w_stall[g]     = u_if.stall;
    assign w_we[g]        = u_if.rf_we;
    assign w_wa[g]        = u_if.rf_wa;
    assign w_wd[g]        = u_if.rf_wd;
    assign w_busy[g]      = u_if.busy;
    assign w_done[g]      = u_if.mul_done;

    exp_t mon_e;
    always @(negedge clk) begin
      if (started && (w_we[g] || w_done[g])) begin
        if (sb_q[g].size() == 0) begin
          check($sformatf("sb_empty%0d", g), 64'(sb_q[g].size()), 64'd1);
        end else begin
          mon_e = sb_q[g].pop_front();
          check($sformatf("we%0d", g),   64'(w_we[g]),   64'(mon_e.we));
          check($sformatf("wa%0d", g),   64'(w_wa[g]),   64'(mon_e.wa));
          check($sformatf("wd%0d", g),   64'(w_wd[g]),   64'(mon_e.wd));
          check($sformatf("done%0d", g), 64'(w_done[g]), 64'(mon_e.done));
          check($sformatf("cyc%0d", g),  64'(cyc),       64'(mon_e.cyc));
        end
      end
    end
  end

  // Queue the two expected write-port cycles of a MUL issued in cycle t.
  task automatic push_exp(input int g, input logic [4:0] da, input logic [63:0] p, input int t,
                          input bit with_hi);
    exp_t e;
    logic [4:0] hi_a;
    hi_a = da + 5'd1;
    e.we = 1'b1; e.wa = da; e.wd = p[31:0]; e.done = 1'b0; e.cyc = t + LATS[g] + 1;
    sb_q[g].push_back(e);
    if (with_hi) begin
      e.we = (hi_a != 5'd0); e.wa = hi_a; e.wd = p[63:32]; e.done = 1'b1; e.cyc = t + LATS[g] + 2;
      sb_q[g].push_back(e);
    end
  endtask

  // Issue a MUL (called #1 after a rising edge with the instance idle), hold
  // issue_mul until stall drops, optionally pulse flush in cycle T+fl_off.
  task automatic do_mul(input int g, input logic [4:0] da, input logic [63:0] p, input int fl_off);
    int  t;
    int  n;
    logic st;
    t = cyc;
    n = 0;
    r_issue[g] = 1'b1;
    r_da[g]    = da;
    r_fmul[g]  = p;
    push_exp(g, da, p, t, 1'b1);
    for (int i = 0; i < 40; i++) begin
      r_flush[g] = (i == fl_off);
      @(negedge clk);
      st = w_stall[g];
      @(posedge clk); #1;
      if (st) n++;
      else break;
    end
    r_flush[g] = 1'b0;
    r_issue[g] = 1'b0;
    check($sformatf("stall_len%0d", g), 64'(n), 64'(LATS[g] + 2));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int g = 0; g < NDUT; g++) begin
      r_issue[g] = 1'b0; r_da[g] = '0; r_fmul[g] = '0; r_flush[g] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;

    // Reset state of every instance.
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("rst_stall", 64'(w_stall[g]), 64'd0);
      check("rst_we",    64'(w_we[g]),    64'd0);
      check("rst_wa",    64'(w_wa[g]),    64'd0);
      check("rst_wd",    64'(w_wd[g]),    64'd0);
      check("rst_busy",  64'(w_busy[g]),  64'd0);
      check("rst_done",  64'(w_done[g]),  64'd0);
    end
    @(posedge clk); #1;

    // Basic MUL.
    do_mul(0, 5'd5, 64'h0000_0003_8000_0001, -1);
    idle_cycles(2);

    // Latency sweep.
    do_mul(1, 5'd10, 64'hDEAD_BEEF_0123_4567, -1);
    idle_cycles(1);
    do_mul(2, 5'd20, 64'hDEAD_BEEF_0123_4567, -1);
    idle_cycles(1);

    // Register wrap: high word targets R0, so no write but mul_done still pulses.
    do_mul(0, 5'd31, 64'h1111_2222_3333_4444, -1);
    do_mul(2, 5'd31, 64'hAAAA_BBBB_CCCC_DDDD, -1);
    idle_cycles(1);

    // Flush in WR_LO: both writes still land.
    do_mul(0, 5'd14, 64'h5555_6666_7777_8888, LATS[0] + 1);
    idle_cycles(1);

    // Flush in the second WAIT cycle: abandoned, no writes.
    r_issue[0] = 1'b1; r_da[0] = 5'd7; r_fmul[0] = 64'h9999_0000_9999_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    r_flush[0] = 1'b1;
    @(negedge clk);
    check("flush_w2_stall", 64'(w_stall[0]), 64'd1);
    @(posedge clk); #1;
    r_flush[0] = 1'b0; r_issue[0] = 1'b0;
    @(negedge clk);
    check("flush_stall", 64'(w_stall[0]), 64'd0);
    check("flush_busy",  64'(w_busy[0]),  64'd0);
    idle_cycles(6);

    // Issue with flush in IDLE: nothing starts.
    r_issue[0] = 1'b1; r_flush[0] = 1'b1; r_da[0] = 5'd3;
    @(negedge clk);
    check("idle_flush_stall", 64'(w_stall[0]), 64'd0);
    @(posedge clk); #1;
    r_issue[0] = 1'b0; r_flush[0] = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", 64'(w_busy[0]), 64'd0);
    idle_cycles(4);

    // Back-to-back with issue held through WR_HI.
    do_mul(0, 5'd2, 64'h0BAD_F00D_CAFE_0002, -1);
    do_mul(0, 5'd8, 64'h0123_4567_89AB_CDEF, -1);
    do_mul(1, 5'd2, 64'hFEED_0001_BEEF_0002, -1);
    do_mul(1, 5'd8, 64'h7777_0003_4444_0004, -1);
    idle_cycles(2);

    // Reset asserted in WR_LO: WR_LO still visible that cycle, WR_HI never happens.
    t = cyc;
    r_issue[0] = 1'b1; r_da[0] = 5'd12; r_fmul[0] = 64'hABCD_EF01_2345_6789;
    push_exp(0, 5'd12, 64'hABCD_EF01_2345_6789, t, 1'b0);
    repeat (LATS[0] + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_wrlo_stall", 64'(w_stall[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; r_issue[0] = 1'b0;
    @(negedge clk);
    check("post_rst_we",   64'(w_we[0]),    64'd0);
    check("post_rst_wa",   64'(w_wa[0]),    64'd0);
    check("post_rst_wd",   64'(w_wd[0]),    64'd0);
    check("post_rst_done", 64'(w_done[0]),  64'd0);
    check("post_rst_busy", 64'(w_busy[0]),  64'd0);
    check("post_rst_stall",64'(w_stall[0]), 64'd0);
    idle_cycles(4);

    // Fresh MUL after reset.
    do_mul(0, 5'd4, 64'h0000_0042_0000_0024, -1);
    idle_cycles(4);

    for (int g = 0; g < NDUT; g++)
      check($sformatf("sb_left%0d", g), 64'(sb_q[g].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
